mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data and bus data width (multiple of 8; byte select width is DATA_W/8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning bus address width.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, meaning destination register index width.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning maximum bus-wait cycles before abort (at least 1).
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port wd_i  in  REG_ADDR_W  destination register from execute.
REQ-008 SHALL have port wreg_i  in  1  register-write enable from execute.
REQ-009 SHALL have port wdata_i  in  DATA_W  ALU result from execute.
REQ-010 SHALL have port mem_op_i  in  4  memory operation code (package enum).
REQ-011 SHALL have port mem_addr_i  in  ADDR_W  effective address.
REQ-012 SHALL have port store_data_i  in  DATA_W  store operand.
REQ-013 SHALL have port wd_o / wreg_o / wdata_o  out  REG_ADDR_W / 1 / DATA_W  write-back request.
REQ-014 SHALL have port stallreq_o  out  1  pipeline stall request; upstream holds all *_i stable while high.
REQ-015 SHALL have port bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o  out  1 / 1 / ADDR_W / DATA_W/8 / DATA_W  data bus request.
REQ-016 SHALL have port bus_ack_i, bus_rdata_i  in  1 / DATA_W  data bus acknowledge and read data.
REQ-017 SHALL have port align_err_o, bus_err_o  out  1 / 1  one-cycle exception pulses.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-019 SHALL, in IDLE with mem_op_i = NOP, pass wd_i/wreg_i/wdata_i to the outputs combinationally with zero latency and keep stallreq_o at 0.
REQ-020 SHALL decode LB, LBU, LH, LHU, LW, SB, SH and SW, using big-endian byte lanes (address offset 0 selects the most significant byte).
REQ-021 SHALL flag a halfword with addr[0] != 0, or a word with addr[1:0] != 0, as misaligned; it pulses align_err_o for one cycle, issues no bus request, drives wreg_o = 0, does not stall and stays in IDLE.
REQ-022 SHALL, in IDLE with a valid aligned memory op, register the address, byte select, replicated store data and we, go to BUSY, and drive stallreq_o = 1 in that cycle.
REQ-023 SHALL, in BUSY, hold bus_req_o = 1 with stable bus signals, stallreq_o = 1 and wreg_o = 0, and increment the wait counter each cycle.
REQ-024 SHALL, on bus_ack_i in BUSY, capture bus_rdata_i, drop bus_req_o in the next cycle and go to DONE.
REQ-025 SHALL, when the wait counter reaches TIMEOUT without bus_ack_i, drop the request, pulse bus_err_o for one cycle, drive wreg_o = 0 and return to IDLE with stallreq_o = 0.
REQ-026 SHALL, if bus_ack_i arrives in the cycle the counter reaches TIMEOUT, treat it as success.
REQ-027 SHALL, in DONE, drive stallreq_o = 0 and, for a load, drive wd_o = wd_i, wreg_o = wreg_i and wdata_o = the selected lane sign- or zero-extended to DATA_W; for a store it drives wreg_o = 0. It returns to IDLE next cycle.
REQ-028 SHALL give store byte selects for DATA_W = 32 as: SB offset 0..3 -> 1000/0100/0010/0001; SH offset 0/2 -> 1100/0011; SW -> 1111.
REQ-029 SHALL replicate store data across lanes: SB replicates the byte, SH replicates the halfword.
REQ-030 SHALL ignore bus_ack_i outside BUSY.
REQ-031 SHALL, on an unknown mem_op_i code, behave as NOP.

Reset
REQ-032 SHALL, while rst = 1, force the FSM to IDLE and clear the wait counter and captured data.
REQ-033 SHALL, while rst = 1, drive wd_o = 0, wreg_o = 0, wdata_o = 0, stallreq_o = 0, bus_req_o = 0, bus_we_o = 0, bus_sel_o = 0, align_err_o = 0 and bus_err_o = 0.
REQ-034 SHALL, when reset is asserted mid-transaction (BUSY), abandon the transaction on the next edge, with no error pulse.

Structure
REQ-035 SHALL take the mem_op enum, the NOP register address and the zero-word constant from the shared core package.
REQ-036 SHALL place the load lane-select and extend logic in one sub-module, load_align.

Verification
REQ-037 SHALL cover: LW at 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stallreq_o high for 4 cycles, then wdata_o = 0xDEADBEEF with wreg_o = 1 for one cycle.
REQ-038 SHALL cover: LB at offset 1 with rdata 0x12F45678 -> wdata_o = 0xFFFFFFF4; LBU at the same address -> wdata_o = 0x000000F4.
REQ-039 SHALL cover: SH at 0x202 with store data 0x0000ABCD -> bus_sel_o = 0011, bus_wdata_o = 0xABCDABCD, bus_we_o = 1, wreg_o = 0.
REQ-040 SHALL cover: LW at 0x101 -> align_err_o pulses once, bus_req_o stays 0, no stall.
REQ-041 SHALL cover: LW with no ack, TIMEOUT = 4 -> bus_err_o pulses after 4 BUSY cycles, and stallreq_o falls at the same time.
REQ-042 SHALL cover: rst asserted in the second BUSY cycle -> bus_req_o = 0 and stallreq_o = 0 after the next edge, with no error pulse.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared core definitions for the load/store unit: memory op codes, access sizes,
// FSM states and the constants driven on idle write-back ports.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'h0,
    MEM_LB  = 4'h1,
    MEM_LBU = 4'h2,
    MEM_LH  = 4'h3,
    MEM_LHU = 4'h4,
    MEM_LW  = 4'h5,
    MEM_SB  = 4'h6,
    MEM_SH  = 4'h7,
    MEM_SW  = 4'h8
  } mem_op_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} lsu_state_e;

  localparam logic [4:0]  NOP_REG   = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'h0;

  // Unlisted codes collapse to NOP so downstream decode only sees legal ops.
  function automatic mem_op_e decode_op(input logic [3:0] code);
    case (code)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW,
      MEM_SB, MEM_SH, MEM_SW: decode_op = mem_op_e'(code);
      default:                decode_op = MEM_NOP;
    endcase
  endfunction

  function automatic mem_size_e op_size(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_size = SZ_B;
      MEM_LH, MEM_LHU, MEM_SH: op_size = SZ_H;
      default:                 op_size = SZ_W;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    op_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Big-endian lane select for loads: offset 0 is the most significant byte,
// then sign or zero extension to the full data width.
module load_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_op_e                         op_i,
  input  logic [$clog2(DATA_W/8)-1:0]     off_i,
  input  logic [DATA_W-1:0]               rdata_i,
  output logic [DATA_W-1:0]               data_o
);

  localparam int NB = DATA_W / 8;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(rdata_i >> (8 * (NB - 1 - int'(off_i))));
    half_v = 16'(rdata_i >> (8 * (NB - 2 - int'(off_i))));
    case (op_i)
      MEM_LB:  data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      MEM_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_v};
      MEM_LH:  data_o = {{(DATA_W-16){half_v[15]}}, half_v};
      MEM_LHU: data_o = {{(DATA_W-16){1'b0}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage: passes ALU results through, or runs one bus transaction per load/store.
// state | meaning: IDLE - pass-through / accept op; BUSY - bus request held; DONE - write-back or bus error exit
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  stallreq_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W/8-1:0]   bus_sel_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  output logic                  align_err_o,
  output logic                  bus_err_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  mem_op_e           op_q, op_d, op_v;
  mem_size_e         size_v;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     sel_q, sel_d, sel_v;
  logic [DATA_W-1:0] swdata_q, swdata_d, swdata_v;
  logic [DATA_W-1:0] rdata_q, rdata_d, load_data;
  logic              we_q, we_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OFF_W-1:0]  off_v;
  logic              is_mem_v, misalign_v, busy;

  always_comb begin
    op_v       = decode_op(mem_op_i);
    size_v     = op_size(op_v);
    off_v      = mem_addr_i[OFF_W-1:0];
    is_mem_v   = (op_v != MEM_NOP);
    misalign_v = is_mem_v && (((size_v == SZ_H) && off_v[0]) ||
                              ((size_v == SZ_W) && (off_v != '0)));
    case (size_v)
      SZ_B: begin
        sel_v    = NB'(1) << (NB - 1 - int'(off_v));
        swdata_v = {NB{store_data_i[7:0]}};
      end
      SZ_H: begin
        sel_v    = NB'(3) << (NB - 2 - int'(off_v));
        swdata_v = {(NB/2){store_data_i[15:0]}};
      end
      default: begin
        sel_v    = '1;
        swdata_v = store_data_i;
      end
    endcase
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .op_i    (op_q),
    .off_i   (addr_q[OFF_W-1:0]),
    .rdata_i (rdata_q),
    .data_o  (load_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    swdata_d    = swdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stallreq_o  = 1'b0;
    align_err_o = 1'b0;
    bus_err_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (misalign_v) begin
          align_err_o = 1'b1;
          wreg_o      = 1'b0;
        end else if (is_mem_v) begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          op_d       = op_v;
          addr_d     = mem_addr_i;
          sel_d      = sel_v;
          swdata_d   = swdata_v;
          we_d       = op_is_store(op_v);
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        cnt_d      = cnt_q + CNT_W'(1);
        // An ack on the final permitted cycle still wins over the timeout.
        if (bus_ack_i) begin
          rdata_d = bus_rdata_i;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (err_q) begin
          bus_err_o = 1'b1;
          wreg_o    = 1'b0;
        end else if (we_q) begin
          wreg_o = 1'b0;
        end else begin
          wdata_o = load_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      wd_o        = REG_ADDR_W'(NOP_REG);
      wreg_o      = 1'b0;
      wdata_o     = DATA_W'(ZERO_WORD);
      stallreq_o  = 1'b0;
      align_err_o = 1'b0;
      bus_err_o   = 1'b0;
    end
  end

  assign busy        = (state_q == ST_BUSY) && !rst;
  assign bus_req_o   = busy;
  assign bus_we_o    = busy && we_q;
  assign bus_sel_o   = busy ? sel_q : '0;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = swdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MEM_NOP;
      addr_q   <= '0;
      sel_q    <= '0;
      swdata_q <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      swdata_q <= swdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with TIMEOUT = 4; expected values are hand-computed.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  mem_op_i = MEM_NOP;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        align_err_o, bus_err_o;

  int total = 0;
  int bad = 0;

  int          obs_stall, obs_busy, obs_err, obs_align, obs_busy_wreg;
  logic [31:0] obs_addr, obs_bwdata;
  logic [3:0]  obs_sel;
  logic        obs_we;
  logic        exit_wreg, exit_busreq, exit_err;
  logic [31:0] exit_wdata;
  logic [4:0]  exit_wd;
  logic        post_err, post_align, post_stall, post_busreq;

  mem_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Drives one op and records what the DUT does until stallreq_o is low; ack is
  // raised during the ack_cycle-th cycle with bus_req_o high (0 = never).
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_cycle, input logic [4:0] wd,
                         input logic wreg);
    bit exited = 0;
    mem_op_i = op; mem_addr_i = addr; store_data_i = sdata; bus_rdata_i = rdata;
    wd_i = wd; wreg_i = wreg; wdata_i = 32'h5555_0000; bus_ack_i = 1'b0;
    obs_stall = 0; obs_busy = 0; obs_err = 0; obs_align = 0; obs_busy_wreg = 0;
    obs_addr = '0; obs_bwdata = '0; obs_sel = '0; obs_we = 1'b0;
    for (int cyc = 0; cyc < 30 && !exited; cyc++) begin
      @(negedge clk);
      if (bus_err_o) obs_err++;
      if (align_err_o) obs_align++;
      if (!stallreq_o) begin
        exit_wreg = wreg_o; exit_wdata = wdata_o; exit_wd = wd_o;
        exit_busreq = bus_req_o; exit_err = bus_err_o;
        bus_ack_i = 1'b0;
        exited = 1;
      end else begin
        obs_stall++;
        if (bus_req_o) begin
          obs_busy++;
          if (obs_busy == 1) begin
            obs_addr = bus_addr_o; obs_sel = bus_sel_o; obs_we = bus_we_o; obs_bwdata = bus_wdata_o;
          end
          if (wreg_o) obs_busy_wreg++;
        end
        bus_ack_i = bus_req_o && (obs_busy == ack_cycle);
      end
      @(posedge clk); #1;
    end
    total++;
    if (!exited) begin bad++; $display("FAIL txn_bound stall never released op=%0h addr=%h", op, addr); end
    mem_op_i = MEM_NOP; wreg_i = 1'b0; wd_i = '0; bus_ack_i = 1'b0;
    @(negedge clk);
    post_err = bus_err_o; post_align = align_err_o; post_stall = stallreq_o; post_busreq = bus_req_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_op_i = MEM_LW; mem_addr_i = 32'h101; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'd123;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (wd_o !== 5'd0) begin bad++; $display("FAIL rst_wd got=%h exp=0", wd_o); end
    total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL rst_wreg got=%b exp=0", wreg_o); end
    total++; if (wdata_o !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", wdata_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stallreq_o); end
    total++; if ({bus_req_o, bus_we_o, bus_sel_o} !== 6'b0) begin bad++; $display("FAIL rst_bus got=%b%b%b exp=0", bus_req_o, bus_we_o, bus_sel_o); end
    total++; if ({align_err_o, bus_err_o} !== 2'b00) begin bad++; $display("FAIL rst_errs got=%b%b exp=00", align_err_o, bus_err_o); end
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = MEM_NOP; wreg_i = 1'b0;
  endtask

  task automatic test_nop();
    mem_op_i = MEM_NOP; mem_addr_i = 32'h103; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    total++; if (wd_o !== 5'd5) begin bad++; $display("FAIL nop_wd got=%h exp=05", wd_o); end
    total++; if (wreg_o !== 1'b1) begin bad++; $display("FAIL nop_wreg got=%b exp=1", wreg_o); end
    total++; if (wdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL nop_wdata got=%h exp=cafef00d", wdata_o); end
    total++; if ({stallreq_o, bus_req_o, align_err_o} !== 3'b000) begin bad++; $display("FAIL nop_ctrl got=%b%b%b exp=000", stallreq_o, bus_req_o, align_err_o); end
    @(posedge clk); #1;
    mem_op_i = 4'hC; mem_addr_i = 32'h101; wd_i = 5'd9; wdata_i = 32'h1234_5678;
    @(negedge clk);
    total++; if ({wreg_o, wdata_o} !== {1'b1, 32'h1234_5678}) begin bad++; $display("FAIL unk_pass got=%b/%h exp=1/12345678", wreg_o, wdata_o); end
    total++; if ({stallreq_o, bus_req_o, align_err_o} !== 3'b000) begin bad++; $display("FAIL unk_ctrl got=%b%b%b exp=000", stallreq_o, bus_req_o, align_err_o); end
    @(posedge clk); #1;
    mem_op_i = MEM_NOP; bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus_ack_i = 1'b0; wdata_i = 32'h77;
    @(negedge clk);
    total++; if ({stallreq_o, wreg_o, wdata_o} !== {1'b0, 1'b1, 32'h77}) begin bad++; $display("FAIL ack_idle got=%b%b/%h exp=01/00000077", stallreq_o, wreg_o, wdata_o); end
    @(posedge clk); #1;
    wreg_i = 1'b0;
  endtask

  task automatic test_lw();
    run_txn(MEM_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, 5'd3, 1'b1);
    total++; if (obs_stall !== 4) begin bad++; $display("FAIL lw_stall got=%0d exp=4", obs_stall); end
    total++; if (obs_busy !== 3) begin bad++; $display("FAIL lw_busy got=%0d exp=3", obs_busy); end
    total++; if ({obs_addr, obs_sel, obs_we} !== {32'h100, 4'b1111, 1'b0}) begin bad++; $display("FAIL lw_bus got=%h/%b/%b exp=00000100/1111/0", obs_addr, obs_sel, obs_we); end
    total++; if (obs_busy_wreg !== 0) begin bad++; $display("FAIL lw_busy_wreg got=%0d exp=0", obs_busy_wreg); end
    total++; if ({exit_wreg, exit_wd, exit_wdata} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin bad++; $display("FAIL lw_wb got=%b/%h/%h exp=1/03/deadbeef", exit_wreg, exit_wd, exit_wdata); end
    total++; if ({exit_busreq, post_stall, post_busreq} !== 3'b000) begin bad++; $display("FAIL lw_after got=%b%b%b exp=000", exit_busreq, post_stall, post_busreq); end
  endtask

  task automatic test_sub_word_loads();
    logic [3:0]  ops[6]   = '{MEM_LB, MEM_LBU, MEM_LB, MEM_LH, MEM_LHU, MEM_LH};
    logic [31:0] addrs[6] = '{32'h101, 32'h101, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] rds[6]   = '{32'h12F4_5678, 32'h12F4_5678, 32'h12F4_5678, 32'h1234_ABCD, 32'h1234_ABCD, 32'h8001_1234};
    logic [31:0] exps[6]  = '{32'hFFFF_FFF4, 32'h0000_00F4, 32'h0000_0078, 32'hFFFF_ABCD, 32'h0000_ABCD, 32'hFFFF_8001};
    logic [3:0]  sels[6]  = '{4'b0100, 4'b0100, 4'b0001, 4'b0011, 4'b0011, 4'b1100};
    for (int i = 0; i < 6; i++) begin
      run_txn(ops[i], addrs[i], 32'h0, rds[i], 1, 5'd10, 1'b1);
      total++; if (exit_wdata !== exps[i]) begin bad++; $display("FAIL load%0d_data got=%h exp=%h", i, exit_wdata, exps[i]); end
      total++; if ({obs_sel, exit_wreg, obs_stall} !== {sels[i], 1'b1, 32'd2}) begin bad++; $display("FAIL load%0d_ctl sel=%b wreg=%b stall=%0d exp sel=%b wreg=1 stall=2", i, obs_sel, exit_wreg, obs_stall, sels[i]); end
    end
  endtask

  task automatic test_stores();
    logic [3:0]  ops[4]   = '{MEM_SH, MEM_SB, MEM_SB, MEM_SW};
    logic [31:0] addrs[4] = '{32'h202, 32'h300, 32'h301, 32'h400};
    logic [31:0] sds[4]   = '{32'h0000_ABCD, 32'h0000_005A, 32'h0000_005A, 32'h1122_3344};
    logic [31:0] bwd[4]   = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h1122_3344};
    logic [3:0]  sels[4]  = '{4'b0011, 4'b1000, 4'b0100, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      run_txn(ops[i], addrs[i], sds[i], 32'h0, 2, 5'd4, 1'b1);
      total++; if ({obs_sel, obs_bwdata} !== {sels[i], bwd[i]}) begin bad++; $display("FAIL st%0d_lanes got=%b/%h exp=%b/%h", i, obs_sel, obs_bwdata, sels[i], bwd[i]); end
      total++; if ({obs_we, obs_addr, exit_wreg} !== {1'b1, addrs[i], 1'b0}) begin bad++; $display("FAIL st%0d_ctl got=%b/%h/%b exp=1/%h/0", i, obs_we, obs_addr, exit_wreg, addrs[i]); end
    end
  endtask

  task automatic test_misalign();
    logic [3:0]  ops[3]   = '{MEM_LW, MEM_SW, MEM_LH};
    logic [31:0] addrs[3] = '{32'h101, 32'h402, 32'h201};
    for (int i = 0; i < 3; i++) begin
      run_txn(ops[i], addrs[i], 32'h0, 32'h0, 1, 5'd6, 1'b1);
      total++; if ({obs_align, post_align} !== {32'd1, 1'b0}) begin bad++; $display("FAIL mis%0d_pulse got=%0d/%b exp=1/0", i, obs_align, post_align); end
      total++; if ({obs_stall, obs_busy, exit_busreq, exit_wreg} !== {32'd0, 32'd0, 1'b0, 1'b0}) begin bad++; $display("FAIL mis%0d_ctl stall=%0d busy=%0d req=%b wreg=%b exp 0", i, obs_stall, obs_busy, exit_busreq, exit_wreg); end
    end
  endtask

  task automatic test_timeout();
    run_txn(MEM_LW, 32'h500, 32'h0, 32'h0, 0, 5'd8, 1'b1);
    total++; if ({obs_busy, obs_stall} !== {32'd4, 32'd5}) begin bad++; $display("FAIL to_cycles busy=%0d stall=%0d exp busy=4 stall=5", obs_busy, obs_stall); end
    total++; if ({exit_err, obs_err, post_err} !== {1'b1, 32'd1, 1'b0}) begin bad++; $display("FAIL to_pulse got=%b/%0d/%b exp=1/1/0", exit_err, obs_err, post_err); end
    total++; if ({exit_wreg, exit_busreq} !== 2'b00) begin bad++; $display("FAIL to_exit got=%b%b exp=00", exit_wreg, exit_busreq); end
  endtask

  task automatic test_ack_at_limit();
    run_txn(MEM_LW, 32'h504, 32'h0, 32'hA5A5_0F0F, 4, 5'd12, 1'b1);
    total++; if ({obs_busy, obs_err} !== {32'd4, 32'd0}) begin bad++; $display("FAIL lim_cycles busy=%0d err=%0d exp busy=4 err=0", obs_busy, obs_err); end
    total++; if ({exit_wreg, exit_wdata} !== {1'b1, 32'hA5A5_0F0F}) begin bad++; $display("FAIL lim_wb got=%b/%h exp=1/a5a50f0f", exit_wreg, exit_wdata); end
  endtask

  task automatic test_reset_mid_busy();
    int errs = 0;
    mem_op_i = MEM_LW; mem_addr_i = 32'h600; wreg_i = 1'b1; wd_i = 5'd2; bus_ack_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rstm_busy1 got=%b exp=1", bus_req_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({bus_req_o, stallreq_o} !== 2'b00) begin bad++; $display("FAIL rstm_during got=%b%b exp=00", bus_req_o, stallreq_o); end
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = MEM_NOP; wreg_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_err_o || bus_req_o || stallreq_o) errs++;
      @(posedge clk); #1;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL rstm_after active_cycles=%0d exp=0", errs); end
    run_txn(MEM_LW, 32'h700, 32'h0, 32'h0BAD_F00D, 1, 5'd1, 1'b1);
    total++; if ({exit_wreg, exit_wdata, obs_err} !== {1'b1, 32'h0BAD_F00D, 32'd0}) begin bad++; $display("FAIL rstm_next got=%b/%h/%0d exp=1/0badf00d/0", exit_wreg, exit_wdata, obs_err); end
  endtask

  initial begin
    #1;
    test_reset();
    test_nop();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
